// File: rtl/insn_fetch_stage.sv
// insn_fetch_stage: credit-limited instruction fetch with response FIFO, stall and redirect flush
module insn_fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-3:0] RESET_ADDR = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-3:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-3:0] redirect_addr,
  input  logic                  stall,
  output logic                  insn_valid,
  output logic [ADDR_WIDTH-3:0] insn_addr,
  output logic [31:0]           insn
);
  localparam int AW = ADDR_WIDTH - 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state;
  logic [AW-1:0] pc;
  logic [CW-1:0] inflight, stale, count, base, stale_n;
  logic [AW-1:0] aq [FIFO_DEPTH];
  logic [AW-1:0] fa [FIFO_DEPTH];
  logic [31:0] fd [FIFO_DEPTH];
  logic [PW-1:0] aq_wr, aq_rd, wr, rd;
  logic req_fire, keep, pop;
  always_comb begin
    imem_req_valid = !rst && state == RUN && !redirect_valid &&
                     ({1'b0, inflight} + {1'b0, count} < DEPTH);
    imem_req_addr = rst ? '0 : pc;
    req_fire = imem_req_valid && imem_req_ready;
    keep = imem_rsp_valid && !redirect_valid && stale == '0;
    insn_valid = !rst && count != '0;
    insn_addr = rst ? '0 : fa[rd];
    insn = rst ? '0 : fd[rd];
    pop = insn_valid && !stall;
    // a redirect in RUN marks everything in flight stale; in FLUSH it already is
    base = (redirect_valid && state == RUN) ? inflight : stale;
    stale_n = base - CW'(imem_rsp_valid && base != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_ADDR;
      inflight <= '0;
      stale <= '0;
      count <= '0;
      aq_wr <= '0;
      aq_rd <= '0;
      wr <= '0;
      rd <= '0;
      state <= RUN;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(imem_rsp_valid);
      stale <= stale_n;
      state <= stale_n != '0 ? FLUSH : RUN;
      if (req_fire) aq_wr <= aq_wr + PW'(1);
      if (imem_rsp_valid) aq_rd <= aq_rd + PW'(1);
      if (redirect_valid) begin
        pc <= redirect_addr;
        count <= '0;
        wr <= '0;
        rd <= '0;
      end else begin
        if (req_fire) pc <= pc + AW'(1);
        if (keep) wr <= wr + PW'(1);
        if (pop) rd <= rd + PW'(1);
        count <= count + CW'(keep) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) aq[aq_wr] <= pc;
    if (keep) begin
      fa[wr] <= aq[aq_rd];
      fd[wr] <= imem_rsp_data;
    end
  end
  always_ff @(posedge clk)
    if (!rst && imem_rsp_valid) assert (inflight != '0);
endmodule
